// File: rtl/fifo_60bit_unpack_rd.sv
// Read-side adapter: drains fifo_256_60bit and emits each 60-bit word as three 20-bit beats.
// Define UNPACK_BEAT_CNT_EN to build the 16-bit accepted-beat counter on beat_cnt.
module fifo_60bit_unpack_rd #(
    parameter int DW = 60,
    parameter int BW = 20
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_dout,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [15:0]   beat_cnt
);

    logic [DW-1:0] r_buf [2];
    logic          r_head;
    logic [1:0]    r_cnt;
    logic          r_inflight;
    logic [1:0]    r_beat;

    logic          w_flush;
    logic          w_xfer;
    logic          w_pop;
    logic          w_tail;
    logic [DW-1:0] w_head_word;

    assign w_flush = !resetn || clr;
    assign w_xfer  = out_valid && out_ready;
    assign w_pop   = w_xfer && (r_beat == 2'd2);
    // Tail slot is head+cnt mod 2; a capture never happens with cnt == 2.
    assign w_tail  = r_head ^ r_cnt[0];

    // Words already buffered plus the one returning from the RAM must leave room.
    assign fifo_re = resetn && !clr && !fifo_empty
                     && (({1'b0, r_cnt} + {2'b00, r_inflight}) < 3'd2);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_head     <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
            r_beat     <= 2'd0;
        end else begin
            r_inflight <= fifo_re;
            if (w_xfer) begin
                r_beat <= w_pop ? 2'd0 : r_beat + 2'd1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: the word buffer has no reset; cnt == 0 already marks every slot as empty.
    always_ff @(posedge clk) begin
        if (!w_flush && r_inflight) begin
            r_buf[w_tail] <= fifo_dout;
        end
    end

    assign w_head_word = r_buf[r_head];
    assign out_valid   = (r_cnt != 2'd0);
    assign out_last    = out_valid && (r_beat == 2'd2);

    // NOTE: every path through this block assigns out_data, so no latch is inferred.
    always_comb begin
        out_data = w_head_word[BW-1:0];
        case (r_beat)
            2'd1:    out_data = w_head_word[2*BW-1:BW];
            2'd2:    out_data = w_head_word[3*BW-1:2*BW];
            default: out_data = w_head_word[BW-1:0];
        endcase
    end

`ifdef UNPACK_BEAT_CNT_EN
    logic [15:0] r_beat_cnt;

    // Flush wins over a same-cycle accepted beat; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_beat_cnt <= 16'h0000;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`else
    assign beat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_60bit_unpack_rd.sv
// Directed bench for fifo_60bit_unpack_rd with a behavioural one-cycle-latency FIFO in front.
module tb_fifo_60bit_unpack_rd;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clr;
    logic        fifo_empty;
    logic        fifo_re;
    logic [59:0] fifo_dout;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] beat_cnt;

    int errors = 0;
    int checks = 0;

    fifo_60bit_unpack_rd #(.DW(60), .BW(20)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (clr),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read, flushed by clr.
    logic [59:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_re) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Monitors: read pulses, illegal reads, and sink-side word reassembly.
    int          re_count = 0;
    int          bad_re   = 0;
    int          part_n   = 0;
    logic [59:0] part;
    logic [59:0] rx_q [$];

    always @(posedge clk) begin
        if (fifo_re) re_count++;
        if (fifo_re && fifo_empty) bad_re++;
        if (!resetn || clr) begin
            part_n = 0;
        end else if (out_valid && out_ready && part_n < 3) begin
            part[part_n*20 +: 20] = out_data;
            if (out_last) begin
                rx_q.push_back(part);
                part_n = 0;
            end else begin
                part_n++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [59:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic expect_beat(input string name, input logic [19:0] d, input logic last);
        check({name, "_valid"}, {63'd0, out_valid}, {63'd0, 1'b1});
        check({name, "_data"}, {44'd0, out_data}, {44'd0, d});
        check({name, "_last"}, {63'd0, out_last}, {63'd0, last});
    endtask

    function automatic logic [63:0] exp_bc(input int n);
`ifdef UNPACK_BEAT_CNT_EN
        return 64'(n);
`else
        return 64'(n * 0);
`endif
    endfunction

    logic [59:0] exp_w [200];
    logic [63:0] rnd;
    int          re_base;
    int          cyc;

    initial begin
        resetn    = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_re",    64'(fifo_re),   64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last",  64'(out_last),  64'd0);
        check("rst_cnt",   64'(beat_cnt),  64'd0);

        // Single word: latency and LSB-first slicing.
        resetn = 1'b1;
        push(60'h0123456789ABCDE);
        #1 check("sw_re", 64'(fifo_re), 64'd1);
        tick();
        check("sw_latency", 64'(out_valid), 64'd0);
        tick(); expect_beat("sw_b0", 20'hABCDE, 1'b0);
        tick(); expect_beat("sw_b1", 20'h56789, 1'b0);
        tick(); expect_beat("sw_b2", 20'h01234, 1'b1);
        tick();
        check("sw_idle", 64'(out_valid), 64'd0);
        check("sw_cnt",  64'(beat_cnt), exp_bc(3));

        // Flush clears the counter, then stream 10 words back to back.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", 64'(beat_cnt), 64'd0);
        re_base = re_count;
        for (int i = 0; i < 10; i++)
            push({20'hA0000 + 20'(3*i+2), 20'hA0000 + 20'(3*i+1), 20'hA0000 + 20'(3*i)});
        tick(); tick();
        for (int n = 0; n < 30; n++) begin
            check($sformatf("st_valid%0d", n), 64'(out_valid), 64'd1);
            check($sformatf("st_data%0d", n), 64'(out_data), 64'(20'hA0000 + 20'(n)));
            tick();
        end
        check("st_idle", 64'(out_valid), 64'd0);
        check("st_re",   64'(re_count - re_base), 64'd10);
        check("st_cnt",  64'(beat_cnt), exp_bc(30));

        // Backpressure for 8 cycles with beat 1 of the first word pending.
        re_base = re_count;
        for (int i = 0; i < 5; i++)
            push({20'hB0000 + 20'(3*i+2), 20'hB0000 + 20'(3*i+1), 20'hB0000 + 20'(3*i)});
        tick(); tick();
        check("bp_b0", 64'(out_data), 64'(20'hB0000));
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("bp_hold%0d", c), 64'(out_data), 64'(20'hB0001));
            tick();
        end
        check("bp_re_stop", 64'(re_count - re_base), 64'd2);
        check("bp_re_low",  64'(fifo_re), 64'd0);
        out_ready = 1'b1;
        for (int n = 1; n < 15; n++) begin
            check($sformatf("bp_valid%0d", n), 64'(out_valid), 64'd1);
            check($sformatf("bp_data%0d", n), 64'(out_data), 64'(20'hB0000 + 20'(n)));
            tick();
        end
        check("bp_idle",   64'(out_valid), 64'd0);
        check("bp_re_all", 64'(re_count - re_base), 64'd5);

        // Random out_ready over 200 random words; order must be preserved.
        rx_q.delete();
        for (int i = 0; i < 200; i++) begin
            rnd      = {$urandom(), $urandom()};
            exp_w[i] = rnd[59:0];
            push(exp_w[i]);
        end
        cyc = 0;
        while (rx_q.size() < 200 && cyc < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("rnd_words", 64'(rx_q.size()), 64'd200);
        for (int i = 0; i < 200; i++)
            if (i < rx_q.size()) check($sformatf("rnd_w%0d", i), 64'(rx_q[i]), 64'(exp_w[i]));
        check("no_re_when_empty", 64'(bad_re), 64'd0);

        // clr one cycle after fifo_re while beat 1 is pending.
        push(60'h333332222211111);
        tick(); tick();
        check("cl_b0", 64'(out_data), 64'(20'h11111));
        push(60'h666665555544444);
        #1 check("cl_re", 64'(fifo_re), 64'd1);
        tick();
        check("cl_b1", 64'(out_data), 64'(20'h22222));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cl_valid", 64'(out_valid), 64'd0);
        check("cl_cnt",   64'(beat_cnt), 64'd0);
        tick();
        check("cl_discard", 64'(out_valid), 64'd0);
        push(60'hFFF000FFF000FFF);
        tick(); tick();
        expect_beat("cl_n0", 20'h00FFF, 1'b0);
        tick(); expect_beat("cl_n1", 20'h0FFF0, 1'b0);
        tick(); expect_beat("cl_n2", 20'hFFF00, 1'b1);
        tick();
        check("cl_idle", 64'(out_valid), 64'd0);

        // One-cycle reset mid-word.
        push(60'h999998888877777);
        push(60'hCCCCCBBBBBAAAAA);
        tick(); tick();
        check("rs_b0", 64'(out_data), 64'(20'h77777));
        tick();
        check("rs_b1", 64'(out_data), 64'(20'h88888));
        resetn = 1'b0;
        tick();
        check("rs_re",    64'(fifo_re),   64'd0);
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_last",  64'(out_last),  64'd0);
        check("rs_cnt",   64'(beat_cnt),  64'd0);
        resetn = 1'b1;
        push(60'hFFFFFEEEEEDDDDD);
        tick(); tick();
        expect_beat("rs_n0", 20'hDDDDD, 1'b0);
        tick(); expect_beat("rs_n1", 20'hEEEEE, 1'b0);
        tick(); expect_beat("rs_n2", 20'hFFFFF, 1'b1);
        tick();
        check("rs_idle",  64'(out_valid), 64'd0);
        check("rs_cnt_3", 64'(beat_cnt), exp_bc(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
